mips_mem_arbiter: RTL and testbench

- Shares the single read-only memory port between the instruction cache and the data cache.
- Sits between both caches' miss ports (addr / read_en / data / dvalid) and the memory model or bus bridge.
- Arbitrates round-robin on ties and holds one transaction at a time open until memory returns dvalid.
- Guards against a hung memory with a timeout that returns an error to the requester.

---
 rtl/mips_mem_arbiter_if.sv | 32 +++
 rtl/mips_mem_arbiter.sv | 109 ++++++++++
 tb/tb_mips_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_arbiter_if.sv
// Miss-port bundle between the two caches, the arbiter and the memory port.
// The slave view belongs to the arbiter; the master view is the cache/memory side.
interface mips_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        i_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic [31:0] mem_data;
    logic        mem_dvalid;
    logic        gnt_i;
    logic        gnt_d;

    modport slave (
        input  i_req, i_addr, d_req, d_addr, mem_data, mem_dvalid,
        output i_rdata, i_valid, i_err, d_rdata, d_valid, d_err,
        output mem_addr, mem_read_en, gnt_i, gnt_d
    );

    modport master (
        output i_req, i_addr, d_req, d_addr, mem_data, mem_dvalid,
        input  i_rdata, i_valid, i_err, d_rdata, d_valid, d_err,
        input  mem_addr, mem_read_en, gnt_i, gnt_d
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Shares one read-only memory port between the icache and dcache miss ports.
// One transaction open at a time, round-robin on ties, with a hung-memory timeout
// that completes the request with an error flag and zero data.
module mips_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    mips_mem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_I  = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]       state;
    logic             last_d;      // 1: last grant went to the dcache
    logic [CNT_W-1:0] cnt;
    logic [31:0]      mem_addr_r;
    logic [31:0]      i_rdata_r;
    logic [31:0]      d_rdata_r;
    logic             i_valid_r;
    logic             i_err_r;
    logic             d_valid_r;
    logic             d_err_r;
    logic             pick_d;

    // dcache wins when it is alone or when a tie arrives and the icache had the last grant
    assign pick_d = bus.d_req & (~bus.i_req | ~last_d);

    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_read_en = (state == BUSY_I) || (state == BUSY_D);
    assign bus.gnt_i       = (state == BUSY_I);
    assign bus.gnt_d       = (state == BUSY_D);
    assign bus.i_rdata     = i_rdata_r;
    assign bus.i_valid     = i_valid_r;
    assign bus.i_err       = i_err_r;
    assign bus.d_rdata     = d_rdata_r;
    assign bus.d_valid     = d_valid_r;
    assign bus.d_err       = d_err_r;

    // Arbitration FSM, timeout counter and registered completion outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_d     <= 1'b0;
            cnt        <= '0;
            mem_addr_r <= '0;
            i_rdata_r  <= '0;
            d_rdata_r  <= '0;
            i_valid_r  <= 1'b0;
            i_err_r    <= 1'b0;
            d_valid_r  <= 1'b0;
            d_err_r    <= 1'b0;
        end else begin
            // completion flags are single-cycle pulses
            i_valid_r <= 1'b0;
            i_err_r   <= 1'b0;
            d_valid_r <= 1'b0;
            d_err_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        cnt    <= '0;
                        last_d <= pick_d;
                        if (pick_d) begin
                            state      <= BUSY_D;
                            mem_addr_r <= bus.d_addr;
                        end else begin
                            state      <= BUSY_I;
                            mem_addr_r <= bus.i_addr;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    cnt <= cnt + CNT_ONE;
                    if (bus.mem_dvalid) begin
                        state <= RELEASE;
                        if (state == BUSY_I) begin
                            i_rdata_r <= bus.mem_data;
                            i_valid_r <= 1'b1;
                        end else begin
                            d_rdata_r <= bus.mem_data;
                            d_valid_r <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // memory never answered: complete with an error and no data
                        state <= RELEASE;
                        if (state == BUSY_I) begin
                            i_rdata_r <= '0;
                            i_valid_r <= 1'b1;
                            i_err_r   <= 1'b1;
                        end else begin
                            d_rdata_r <= '0;
                            d_valid_r <= 1'b1;
                            d_err_r   <= 1'b1;
                        end
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized bench for mips_mem_arbiter: cache and memory agents plus a
// transaction-level reference of the arbitration rules.
module tb_mips_mem_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_mem_arbiter_if bus();

    mips_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // reference: open side (0 none, 1 I, 2 D), busy cycles elapsed, release cycle
    int          m_open, m_busy, m_last, m_vside;
    bit          m_rel, m_verr;
    logic [31:0] m_addr, m_vdata, m_i_rdata, m_d_rdata;
    // inputs as seen at the edge being modelled
    logic        s_rst, s_i_req, s_d_req, s_dv;
    logic [31:0] s_i_addr, s_d_addr, s_md;

    // agent knobs
    bit          i_auto, d_auto, jitter, noise, rand_rst, ovr_en;
    int          req_rate, mem_mode, mem_fixed, mem_cyc, mem_delay;
    logic [31:0] ovr_data;

    // observed DUT grants and error completions
    int          dut_log[$];
    bit          pg_i, pg_d;
    int          obs_d_err;

    task automatic model_update();
        m_vside = 0;
        if (s_rst) begin
            m_open = 0; m_rel = 0; m_last = 1; m_addr = '0;
            m_i_rdata = '0; m_d_rdata = '0;
        end else if (m_rel) begin
            m_rel = 0;
        end else if (m_open == 0) begin
            if (s_i_req || s_d_req) begin
                if (s_i_req && s_d_req) m_open = (m_last == 1) ? 2 : 1;
                else                    m_open = s_d_req ? 2 : 1;
                m_last = m_open;
                m_addr = (m_open == 2) ? s_d_addr : s_i_addr;
                m_busy = 0;
            end
        end else begin
            m_busy++;
            if (s_dv) begin
                m_vside = m_open; m_vdata = s_md; m_verr = 0;
            end else if (m_busy == TO) begin
                m_vside = m_open; m_vdata = '0; m_verr = 1;
            end
            if (m_vside != 0) begin
                if (m_vside == 1) m_i_rdata = m_vdata;
                else              m_d_rdata = m_vdata;
                m_open = 0;
                m_rel  = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk_val("mem_read_en", 32'(bus.mem_read_en), 32'(m_open != 0));
        chk_val("gnt_i", 32'(bus.gnt_i), 32'(m_open == 1));
        chk_val("gnt_d", 32'(bus.gnt_d), 32'(m_open == 2));
        chk_val("mem_addr", bus.mem_addr, m_addr);
        chk_val("i_valid", 32'(bus.i_valid), 32'(m_vside == 1));
        chk_val("i_err", 32'(bus.i_err), 32'(m_vside == 1 && m_verr));
        chk_val("i_rdata", bus.i_rdata, m_i_rdata);
        chk_val("d_valid", 32'(bus.d_valid), 32'(m_vside == 2));
        chk_val("d_err", 32'(bus.d_err), 32'(m_vside == 2 && m_verr));
        chk_val("d_rdata", bus.d_rdata, m_d_rdata);
    endtask

    task automatic drive_agents();
        if (bus.gnt_i && !pg_i) dut_log.push_back(1);
        if (bus.gnt_d && !pg_d) dut_log.push_back(2);
        pg_i = bus.gnt_i;
        pg_d = bus.gnt_d;
        if (bus.d_valid && bus.d_err) obs_d_err++;
        // memory: answers in the mem_delay-th read_en cycle, 0 means never
        if (bus.mem_read_en) begin
            mem_cyc++;
            if (mem_cyc == 1) begin
                if (mem_mode == 0) mem_delay = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 10));
                else if (mem_mode == 1) mem_delay = mem_fixed;
                else mem_delay = 0;
            end
            if (mem_delay != 0 && mem_cyc == mem_delay) begin
                bus.mem_dvalid = 1'b1;
                bus.mem_data   = ovr_en ? ovr_data : hash(bus.mem_addr);
            end else begin
                bus.mem_dvalid = 1'b0;
                bus.mem_data   = $urandom;
            end
        end else begin
            mem_cyc        = 0;
            bus.mem_dvalid = noise && ($urandom_range(0, 3) == 0);
            bus.mem_data   = $urandom;
        end
        // requesters: hold req until valid, then drop it
        if (bus.i_valid) bus.i_req = 1'b0;
        else if (!bus.i_req && i_auto && $urandom_range(0, 3) < req_rate) begin
            bus.i_req = 1'b1; bus.i_addr = $urandom & 32'hFFFF_FFFC;
        end else if (bus.i_req && jitter && $urandom_range(0, 3) == 0) bus.i_addr = $urandom & 32'hFFFF_FFFC;
        if (bus.d_valid) bus.d_req = 1'b0;
        else if (!bus.d_req && d_auto && $urandom_range(0, 3) < req_rate) begin
            bus.d_req = 1'b1; bus.d_addr = $urandom & 32'hFFFF_FFFC;
        end else if (bus.d_req && jitter && $urandom_range(0, 3) == 0) bus.d_addr = $urandom & 32'hFFFF_FFFC;
        if (rand_rst) rst = ($urandom_range(0, 199) == 0);
    endtask

    task automatic step();
        s_rst = rst; s_i_req = bus.i_req; s_d_req = bus.d_req;
        s_i_addr = bus.i_addr; s_d_addr = bus.d_addr;
        s_dv = bus.mem_dvalid; s_md = bus.mem_data;
        @(posedge clk);
        @(negedge clk);
        model_update();
        check_outputs();
        drive_agents();
    endtask

    initial begin
        int start;
        int errs0;
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
        bus.mem_data = '0; bus.mem_dvalid = 1'b0;
        i_auto = 0; d_auto = 0; jitter = 0; noise = 0; rand_rst = 0; ovr_en = 0;
        req_rate = 0; mem_mode = 0; mem_fixed = 1; mem_cyc = 0; mem_delay = 0;
        ovr_data = '0; pg_i = 0; pg_d = 0; obs_d_err = 0;
        m_open = 0; m_busy = 0; m_last = 1; m_rel = 0; m_verr = 0; m_vside = 0;
        m_addr = '0; m_vdata = '0; m_i_rdata = '0; m_d_rdata = '0;
        repeat (2) step();
        rst = 1'b0;

        // single icache miss, fixed memory word after three read cycles
        mem_mode = 1; mem_fixed = 3; ovr_en = 1; ovr_data = 32'hDEAD_BEEF;
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        repeat (8) step();
        chk_val("t1_i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        ovr_en = 0;

        // tie right after reset goes to the dcache
        rst = 1'b1; step(); rst = 1'b0;
        start = dut_log.size();
        mem_mode = 0;
        bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.d_req = 1'b1; bus.d_addr = 32'h200;
        repeat (30) step();
        chk_val("t2_grants", 32'(dut_log.size() - start), 32'd2);
        if (dut_log.size() >= start + 2) begin
            chk_val("t2_first_d", 32'(dut_log[start]), 32'd2);
            chk_val("t2_then_i", 32'(dut_log[start + 1]), 32'd1);
        end
        bus.i_req = 1'b1; bus.i_addr = 32'h104; bus.d_req = 1'b1; bus.d_addr = 32'h204;
        repeat (30) step();

        // both sides re-requesting continuously must alternate
        i_auto = 1; d_auto = 1; req_rate = 4;
        repeat (4) step();
        start = dut_log.size();
        repeat (80) step();
        chk_val("t3_grant_cnt", 32'(dut_log.size() - start >= 6), 32'd1);
        for (int j = start + 1; j < dut_log.size(); j++)
            chk_val("t3_alternate", 32'(dut_log[j] != dut_log[j - 1]), 32'd1);
        i_auto = 0; d_auto = 0;
        repeat (30) step();

        // hung memory on a dcache miss, then a pending icache miss served normally
        rst = 1'b1; step(); rst = 1'b0;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        step();
        errs0 = obs_d_err;
        mem_mode = 2;
        bus.d_req = 1'b1; bus.d_addr = 32'h40;
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h20;
        repeat (3) step();
        mem_mode = 1; mem_fixed = 2;
        repeat (20) step();
        chk_val("t4_d_timeout", 32'(obs_d_err - errs0), 32'd1);
        chk_val("t4_d_rdata", bus.d_rdata, 32'd0);
        chk_val("t4_i_rdata", bus.i_rdata, hash(32'h20));

        // reset in the second BUSY_I cycle, then a tie goes to D
        mem_mode = 1; mem_fixed = 5;
        bus.i_req = 1'b1; bus.i_addr = 32'h30;
        repeat (2) step();
        rst = 1'b1; bus.d_req = 1'b1; bus.d_addr = 32'h50;
        step();
        rst = 1'b0;
        start = dut_log.size();
        repeat (20) step();
        if (dut_log.size() > start) chk_val("t5_tie_d", 32'(dut_log[start]), 32'd2);
        else chk_val("t5_grant_seen", 32'd0, 32'd1);

        // address change mid-transaction is ignored
        mem_mode = 1; mem_fixed = 6;
        bus.d_req = 1'b1; bus.d_addr = 32'h40;
        repeat (2) step();
        bus.d_addr = 32'h80;
        repeat (12) step();
        chk_val("t6_d_rdata", bus.d_rdata, hash(32'h40));

        // random traffic
        mem_mode = 0; i_auto = 1; d_auto = 1; req_rate = 1;
        jitter = 1; noise = 1; rand_rst = 1;
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
